// File: rtl/kb_color_pkg.sv
// Shared types, PS/2 set-2 scancode constants and the make-code to colour-index map
// for the keyboard colour selector.
package kb_color_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } st_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } map_t;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // Element i holds the make code for colour index i (digits) or 10+i (letters).
  localparam logic [9:0][7:0] DIGIT_CODES = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };
  localparam logic [5:0][7:0] LETTER_CODES = {
    8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
  };

  function automatic map_t map_code(input logic [7:0] code);
    map_t r;
    r = '0;
    for (int i = 0; i < 10; i++)
      if (code == DIGIT_CODES[i]) r = '{hit: 1'b1, idx: 4'(i)};
    for (int i = 0; i < 6; i++)
      if (code == LETTER_CODES[i]) r = '{hit: 1'b1, idx: 4'(10 + i)};
    return r;
  endfunction

endpackage

// File: rtl/kb_color_decoder_if.sv
// Scan-byte in / colour-select out bundle between the PS/2 receiver and the decoder.
interface kb_color_decoder_if;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic [3:0] color_id;
  logic       confirm;
  logic       prefix_err;

  modport master (output scan_valid, scan_byte, input color_id, confirm, prefix_err);
  modport slave  (input scan_valid, scan_byte, output color_id, confirm, prefix_err);
endinterface

// File: rtl/kb_prefix_timer.sv
// Abandon timer for half-received prefixed codes; expire is high on the last
// cycle of the window while enabled.
module kb_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  assign expire = enable && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/kb_color_decoder.sv
// PS/2 set-2 decoder: digits/letters pick a colour, arrows step it, Enter confirms
// once per press. Stale E0/F0 prefixes are dropped after TIMEOUT_CYCLES.
module kb_color_decoder
  import kb_color_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  kb_color_decoder_if.slave bus
);
  st_e        st, st_n;
  logic [3:0] color_q, color_n;
  logic       confirm_q, confirm_n;
  logic       held_q, held_n;
  logic       err_q, err_n;
  logic       expire;
  map_t       hit;

  assign hit = map_code(bus.scan_byte);

  kb_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.scan_valid || (st == ST_IDLE)),
    .enable (st != ST_IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= ST_IDLE;
      color_q   <= '0;
      confirm_q <= 1'b0;
      held_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st        <= st_n;
      color_q   <= color_n;
      confirm_q <= confirm_n;
      held_q    <= held_n;
      err_q     <= err_n;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    st_n      = st;
    color_n   = color_q;
    confirm_n = 1'b0;
    held_n    = held_q;
    err_n     = err_q;
    if (bus.scan_valid) begin
      case (st)
        ST_IDLE: begin
          if (bus.scan_byte == SC_E0)         st_n = ST_EXT;
          else if (bus.scan_byte == SC_F0)    st_n = ST_BRK;
          else if (bus.scan_byte == SC_ENTER) begin
            confirm_n = !held_q;
            held_n    = 1'b1;
          end else if (hit.hit)               color_n = hit.idx;
        end
        ST_EXT: begin
          if (bus.scan_byte == SC_F0) st_n = ST_EXT_BRK;
          else begin
            st_n = ST_IDLE;
            if (bus.scan_byte == SC_UP)        color_n = color_q + 4'd1;
            else if (bus.scan_byte == SC_DOWN) color_n = color_q - 4'd1;
            else if (bus.scan_byte == SC_ENTER) begin
              confirm_n = !held_q;
              held_n    = 1'b1;
            end
          end
        end
        default: begin
          st_n = ST_IDLE;
          if (bus.scan_byte == SC_ENTER) held_n = 1'b0;
        end
      endcase
    end else if (expire) begin
      st_n  = ST_IDLE;
      err_n = 1'b1;
    end
  end

  assign bus.color_id   = color_q;
  assign bus.confirm    = confirm_q;
  assign bus.prefix_err = err_q;

endmodule

// File: doc/kb_color_decoder.md
KB_COLOR_DECODER -- requirements
Module: kb_color_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, sets the prefix-abandon timeout in clk cycles (1 ms at 100 MHz).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 scan_valid  input  1  one-cycle strobe; scan_byte is valid this cycle.
REQ-005 scan_byte  input  8  raw PS/2 set-2 byte from the receiver stage.
REQ-006 color_id  output  4  selected colour index, registered, fed to keyboard/screen path.
REQ-007 confirm  output  1  one-cycle pulse, once per Enter press.
REQ-008 prefix_err  output  1  sticky flag, set on prefix timeout, cleared by reset only.

Function
REQ-009 FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); a byte is consumed only when scan_valid=1.
REQ-010 IDLE: E0 -> EXT; F0 -> BRK; a make code -> action, stay in IDLE; all other bytes (AA, FA, EE, FC, E1, unmapped) -> ignored, stay in IDLE.
REQ-011 EXT: F0 -> EXT_BRK; any other byte -> extended make action -> IDLE.
REQ-012 BRK and EXT_BRK: any byte -> break action -> IDLE.
REQ-013 Digit makes load color_id: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
REQ-014 Letter makes load color_id: 1C=10, 32=11, 21=12, 23=13, 24=14, 2B=15.
REQ-015 Extended makes: E0 75 (up) sets color_id to color_id+1 mod 16; E0 72 (down) sets it to color_id-1 mod 16; every typematic repeat steps again.
REQ-016 Enter make (5A or E0 5A) pulses confirm only if held_enter=0, then sets held_enter=1; a repeat make while held_enter=1 produces no pulse.
REQ-017 Enter break (F0 5A or E0 F0 5A) clears held_enter; other breaks have no effect.
REQ-018 Latency: color_id and confirm change in the cycle after the scan_valid cycle carrying the final byte of the code.
REQ-019 Prefix timer: counts clk cycles while in EXT, BRK or EXT_BRK; resets on every accepted byte and in IDLE.
REQ-020 Timer reaching TIMEOUT_CYCLES-1 with no byte -> IDLE next cycle, prefix_err=1, color_id unchanged, no confirm.
REQ-021 scan_valid in the same cycle as timeout expiry: the byte wins; it is processed in the current state and no timeout occurs.
REQ-022 Outputs hold between events; confirm is never high for two consecutive cycles.

Reset
REQ-023 rst=0 asynchronously forces state=IDLE, color_id=0, confirm=0, held_enter=0, prefix_err=0, timer=0.
REQ-024 Reset mid-sequence (e.g. after E0) discards the prefix; the first byte after release is decoded from IDLE.
REQ-025 Release of rst is synchronised by the instantiating top; the block adds no internal synchroniser.

Structure
REQ-026 Package kb_color_pkg holds the FSM state enum and every scancode constant (E0, F0, 5A, 75, 72, and the digit and letter tables).
REQ-027 Sub-module kb_prefix_timer (counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYCLES) is the single child instance.
REQ-028 Scancode-to-index mapping is a combinational function in the package; everything else is in the FSM.

Verification
REQ-029 Bytes 26, then F0 26 -> color_id=3 one cycle after the 26 strobe; confirm stays 0; break leaves color_id=3.
REQ-030 color_id=15, then E0 75 -> color_id=0 (wrap); then E0 72 twice -> color_id=14.
REQ-031 Bytes 5A, 5A, 5A, F0 5A, 5A -> exactly two confirm pulses, each one cycle wide.
REQ-032 Byte E0, then idle for TIMEOUT_CYCLES (set to 16) -> IDLE, prefix_err=1; next byte 16 -> color_id=1.
REQ-033 Byte E0 then 1C arriving exactly on the expiry cycle -> treated as extended make, no prefix_err; color_id unchanged because E0 1C is unmapped.
REQ-034 Byte F0, rst pulsed low mid-idle, then 2B -> color_id=0 during reset, then color_id=15 (2B decoded as a make).
